// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and constants for the cache fill arbiter: FSM states, requester IDs,
// block geometry and the block-base helper.
package cache_fill_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL_I,
        FILL_D
    } state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;

    localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFF0;
    localparam int          WORDS_PER_BLOCK   = 8;
    localparam int          WORD_IDX_W        = $clog2(WORDS_PER_BLOCK);
    // Latency the backing memory is expected to have; the controller itself only counts valids.
    localparam int          MEM_LATENCY       = 4;

    function automatic logic [15:0] block_base(input logic [15:0] addr);
        return addr & BLOCK_OFFSET_MASK;
    endfunction

endpackage

// File: rtl/cache_fill_arbiter_counter.sv
// Word-index counter used for both the read-issue and the read-receive side of a block fill.
module fill_word_counter
    import cache_fill_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  incr,
    output logic [WORD_IDX_W-1:0] count,
    output logic                  terminal
);

    logic [WORD_IDX_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (incr) begin
            count_reg <= count_reg + WORD_IDX_W'(1);
        end
    end

    assign count    = count_reg;
    assign terminal = (count_reg == WORD_IDX_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one pipelined main memory between I-cache fills, D-cache fills and
// write-through stores; drives the cache fill/tag write enables and done pulses.
module cache_fill_arbiter
    import cache_fill_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic [15:0] mem_addr,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        i_fill_we,
    output logic        d_fill_we,
    output logic        i_tag_we,
    output logic        d_tag_we,
    output logic        i_done,
    output logic        d_done,
    output logic        wr_done,
    output logic        busy
);

    localparam int CNT_ISSUE = 0;
    localparam int CNT_RECV  = 1;

    state_t      state_reg, state_next;
    logic [15:0] base_reg, base_next;
    logic        i_pend_reg, i_pend_next;
    logic        issue_done_reg, issue_done_next;
    req_id_t     fill_req;

    logic [1:0]            cnt_clear;
    logic [1:0]            cnt_incr;
    logic [1:0]            cnt_term;
    logic [WORD_IDX_W-1:0] cnt_val [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            fill_word_counter u_cnt (
                .clk      (clk),
                .rst      (rst),
                .clear    (cnt_clear[gi]),
                .incr     (cnt_incr[gi]),
                .count    (cnt_val[gi]),
                .terminal (cnt_term[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            i_pend_reg     <= 1'b0;
            issue_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            base_reg       <= base_next;
            i_pend_reg     <= i_pend_next;
            issue_done_reg <= issue_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        base_next       = base_reg;
        i_pend_next     = i_pend_reg;
        issue_done_next = issue_done_reg;
        cnt_clear       = '0;
        cnt_incr        = '0;
        mem_addr        = '0;
        mem_enable      = 1'b0;
        mem_wr          = 1'b0;
        mem_data_in     = '0;
        fill_data       = '0;
        fill_word       = '0;
        i_fill_we       = 1'b0;
        d_fill_we       = 1'b0;
        i_tag_we        = 1'b0;
        d_tag_we        = 1'b0;
        i_done          = 1'b0;
        d_done          = 1'b0;
        wr_done         = 1'b0;
        fill_req        = (state_reg == FILL_D) ? REQ_D : REQ_I;

        case (state_reg)
            IDLE: begin
                // A starved I miss jumps the queue once after a D-side completion.
                if ((i_pend_reg && i_miss) || (!d_miss && !d_wr_req && i_miss)) begin
                    state_next      = FILL_I;
                    base_next       = block_base(i_miss_addr);
                    cnt_clear       = '1;
                    issue_done_next = 1'b0;
                    i_pend_next     = 1'b0;
                end else if (d_miss) begin
                    state_next      = FILL_D;
                    base_next       = block_base(d_miss_addr);
                    cnt_clear       = '1;
                    issue_done_next = 1'b0;
                end else if (d_wr_req) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = d_wr_addr;
                mem_data_in = d_wr_data;
                wr_done     = 1'b1;
                if (i_miss) begin
                    i_pend_next = 1'b1;
                end
                state_next = IDLE;
            end
            FILL_I, FILL_D: begin
                if (!issue_done_reg) begin
                    mem_enable          = 1'b1;
                    mem_addr            = base_reg + {12'd0, cnt_val[CNT_ISSUE], 1'b0};
                    cnt_incr[CNT_ISSUE] = 1'b1;
                    if (cnt_term[CNT_ISSUE]) begin
                        issue_done_next = 1'b1;
                    end
                end
                if (mem_data_valid) begin
                    fill_data          = mem_data_out;
                    fill_word          = cnt_val[CNT_RECV];
                    cnt_incr[CNT_RECV] = 1'b1;
                    i_fill_we          = (fill_req == REQ_I);
                    d_fill_we          = (fill_req == REQ_D);
                    if (cnt_term[CNT_RECV]) begin
                        i_tag_we   = (fill_req == REQ_I);
                        i_done     = (fill_req == REQ_I);
                        d_tag_we   = (fill_req == REQ_D);
                        d_done     = (fill_req == REQ_D);
                        if (fill_req == REQ_D && i_miss) begin
                            i_pend_next = 1'b1;
                        end
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: directed scenarios plus random requesters, checked every
// cycle against a transaction-level model driven by cycles-since-grant.
module tb_cache_fill_arbiter;
    import cache_fill_arbiter_pkg::*;

    localparam int L  = MEM_LATENCY;
    localparam int NW = WORDS_PER_BLOCK;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic [15:0] mem_addr, mem_data_in, mem_data_out, fill_data;
    logic        mem_enable, mem_wr, mem_data_valid;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_done, d_done, wr_done, busy;

    always #5 clk = ~clk;

    cache_fill_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .d_wr_req       (d_wr_req),
        .d_wr_addr      (d_wr_addr),
        .d_wr_data      (d_wr_data),
        .mem_addr       (mem_addr),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_data_valid (mem_data_valid),
        .fill_data      (fill_data),
        .fill_word      (fill_word),
        .i_fill_we      (i_fill_we),
        .d_fill_we      (d_fill_we),
        .i_tag_we       (i_tag_we),
        .d_tag_we       (d_tag_we),
        .i_done         (i_done),
        .d_done         (d_done),
        .wr_done        (wr_done),
        .busy           (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef enum int {M_NONE, M_WR, M_FI, M_FD} mkind_t;
    mkind_t      m_kind = M_NONE;
    int          m_k    = 0;
    logic [15:0] m_base = '0;
    logic        m_pend = 1'b0;

    logic        pipe_v [L];
    logic [15:0] pipe_a [L];
    logic        stray_en = 1'b0;
    logic        drop_i = 1'b0, drop_d = 1'b0, drop_w = 1'b0;

    logic [15:0] s_mem_addr, s_mem_data_in, s_fill_data;
    logic [2:0]  s_fill_word;
    logic        s_mem_enable, s_mem_wr, s_i_fill_we, s_d_fill_we, s_i_tag_we, s_d_tag_we;
    logic        s_i_done, s_d_done, s_wr_done, s_busy;

    function automatic logic [15:0] memfun(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: snapshot and check outputs, step the model and the memory.
    task automatic tick();
        logic [15:0] e_addr, e_din, e_fdata;
        logic [2:0]  e_fword;
        logic        e_en, e_wr, e_ifw, e_dfw, e_itw, e_dtw, e_id, e_dd, e_wd, e_busy;
        mkind_t      n_kind;
        int          n_k, w;
        logic [15:0] n_base;
        logic        n_pend, req_v;
        logic [15:0] req_a;

        @(negedge clk);
        s_mem_addr = mem_addr;   s_mem_data_in = mem_data_in; s_fill_data = fill_data;
        s_fill_word = fill_word; s_mem_enable = mem_enable;   s_mem_wr = mem_wr;
        s_i_fill_we = i_fill_we; s_d_fill_we = d_fill_we;     s_i_tag_we = i_tag_we;
        s_d_tag_we = d_tag_we;   s_i_done = i_done;           s_d_done = d_done;
        s_wr_done = wr_done;     s_busy = busy;

        e_addr = '0; e_din = '0; e_fdata = '0; e_fword = '0;
        e_en = 0; e_wr = 0; e_ifw = 0; e_dfw = 0; e_itw = 0; e_dtw = 0;
        e_id = 0; e_dd = 0; e_wd = 0; e_busy = 0;
        n_kind = m_kind; n_k = m_k + 1; n_base = m_base; n_pend = m_pend;

        case (m_kind)
            M_NONE: begin
                n_k = 1;
                if (m_pend && i_miss) begin
                    n_kind = M_FI; n_base = i_miss_addr & 16'hFFF0; n_pend = 1'b0;
                end else if (d_miss) begin
                    n_kind = M_FD; n_base = d_miss_addr & 16'hFFF0;
                end else if (d_wr_req) begin
                    n_kind = M_WR;
                end else if (i_miss) begin
                    n_kind = M_FI; n_base = i_miss_addr & 16'hFFF0; n_pend = 1'b0;
                end
            end
            M_WR: begin
                e_busy = 1; e_en = 1; e_wr = 1; e_wd = 1;
                e_addr = d_wr_addr; e_din = d_wr_data;
                if (i_miss) n_pend = 1'b1;
                n_kind = M_NONE;
                if (!rst) $display("cycle %0d: store addr=%h data=%h", cyc, d_wr_addr, d_wr_data);
            end
            default: begin
                e_busy = 1;
                if (m_k >= 1 && m_k <= NW) begin
                    e_en   = 1;
                    e_addr = m_base + 16'(2 * (m_k - 1));
                end
                if (m_k >= 1 + L && m_k <= NW + L) begin
                    w       = m_k - 1 - L;
                    e_fword = 3'(w);
                    e_fdata = memfun(m_base + 16'(2 * w));
                    e_ifw   = (m_kind == M_FI);
                    e_dfw   = (m_kind == M_FD);
                end
                if (m_k == NW + L) begin
                    e_itw = (m_kind == M_FI); e_id = e_itw;
                    e_dtw = (m_kind == M_FD); e_dd = e_dtw;
                    if (m_kind == M_FD && i_miss) n_pend = 1'b1;
                    n_kind = M_NONE;
                    if (!rst) $display("cycle %0d: fill %s base=%h", cyc,
                                       (m_kind == M_FI) ? "I" : "D", m_base);
                end
            end
        endcase

        if (!rst) begin
            chk16("mem_addr", s_mem_addr, e_addr);
            chk1("mem_enable", s_mem_enable, e_en);
            chk1("mem_wr", s_mem_wr, e_wr);
            chk16("mem_data_in", s_mem_data_in, e_din);
            chk16("fill_data", s_fill_data, e_fdata);
            chk16("fill_word", 16'(s_fill_word), 16'(e_fword));
            chk1("i_fill_we", s_i_fill_we, e_ifw);
            chk1("d_fill_we", s_d_fill_we, e_dfw);
            chk1("i_tag_we", s_i_tag_we, e_itw);
            chk1("d_tag_we", s_d_tag_we, e_dtw);
            chk1("i_done", s_i_done, e_id);
            chk1("d_done", s_d_done, e_dd);
            chk1("wr_done", s_wr_done, e_wd);
            chk1("busy", s_busy, e_busy);
        end else begin
            n_kind = M_NONE; n_pend = 1'b0;
        end
        drop_i = e_id && !rst;
        drop_d = e_dd && !rst;
        drop_w = e_wd && !rst;
        req_v  = mem_enable && !mem_wr;
        req_a  = mem_addr;

        @(posedge clk);
        #1;
        cyc++;
        m_kind = n_kind; m_k = n_k; m_base = n_base; m_pend = n_pend;
        for (int i = L - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_a[i] = pipe_a[i-1];
        end
        pipe_v[0] = req_v;
        pipe_a[0] = req_a;
        mem_data_valid = pipe_v[L-1];
        mem_data_out   = pipe_v[L-1] ? memfun(pipe_a[L-1]) : 16'($urandom);
        if (!pipe_v[L-1] && stray_en && (m_kind == M_NONE || m_kind == M_WR)
            && $urandom_range(0, 3) == 0) begin
            mem_data_valid = 1'b1;
        end
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 16'hFFF0 | 16'($urandom_range(0, 15));
        return 16'($urandom);
    endfunction

    int quiet;

    initial begin
        rst = 1'b1;
        i_miss = 0; d_miss = 0; d_wr_req = 0;
        i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        mem_data_valid = 1'b0; mem_data_out = '0;
        for (int i = 0; i < L; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = '0;
        end
        #1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk1("reset_busy", s_busy, 1'b0);
        chk1("reset_mem_enable", s_mem_enable, 1'b0);
        chk16("reset_mem_addr", s_mem_addr, 16'h0000);

        // I fill from 0x0024
        i_miss = 1; i_miss_addr = 16'h0024;
        tick();
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 1) chk16("ifill_first_addr", s_mem_addr, 16'h0020);
            if (j == 8) chk16("ifill_last_addr", s_mem_addr, 16'h002E);
            if (j == 9) chk1("ifill_issue_off", s_mem_enable, 1'b0);
            if (j == 5) begin
                chk1("ifill_first_we", s_i_fill_we, 1'b1);
                chk16("ifill_first_word", 16'(s_fill_word), 16'h0000);
            end
            if (j == 12) begin
                chk1("ifill_done", s_i_done, 1'b1);
                chk1("ifill_tag_we", s_i_tag_we, 1'b1);
                chk16("ifill_last_word", 16'(s_fill_word), 16'h0007);
                chk1("ifill_no_d_we", s_d_fill_we, 1'b0);
            end
        end
        i_miss = 0;
        tick();

        // D and I together, then a store competing with the pending I miss
        i_miss = 1; i_miss_addr = 16'h0140; d_miss = 1; d_miss_addr = 16'h2238;
        tick();
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 1) chk16("both_d_first_addr", s_mem_addr, 16'h2230);
            if (j == 12) begin
                chk1("both_d_done", s_d_done, 1'b1);
                chk1("both_i_not_done", s_i_done, 1'b0);
            end
        end
        d_miss = 0; d_wr_req = 1; d_wr_addr = 16'h0400; d_wr_data = 16'h1111;
        tick();
        tick();
        chk16("pend_i_addr", s_mem_addr, 16'h0140);
        chk1("pend_no_store", s_wr_done, 1'b0);
        for (int j = 2; j <= 12; j++) begin
            tick();
            if (j == 12) chk1("pend_i_done", s_i_done, 1'b1);
        end
        i_miss = 0;
        tick();
        tick();
        chk1("late_store_done", s_wr_done, 1'b1);
        chk16("late_store_addr", s_mem_addr, 16'h0400);
        d_wr_req = 0;
        tick();

        // Store
        d_wr_req = 1; d_wr_addr = 16'h1002; d_wr_data = 16'hBEEF;
        tick();
        tick();
        chk1("store_mem_wr", s_mem_wr, 1'b1);
        chk16("store_addr", s_mem_addr, 16'h1002);
        chk16("store_data", s_mem_data_in, 16'hBEEF);
        chk1("store_wr_done", s_wr_done, 1'b1);
        d_wr_req = 0;
        tick();
        chk1("store_busy_after", s_busy, 1'b0);

        // Reset in the middle of an I fill
        i_miss = 1; i_miss_addr = 16'h0300;
        tick();
        for (int j = 1; j <= 5; j++) tick();
        rst = 1;
        tick();
        rst = 0; i_miss = 0;
        tick();
        chk1("rst_busy", s_busy, 1'b0);
        chk1("rst_mem_enable", s_mem_enable, 1'b0);
        chk1("rst_no_done", s_i_done, 1'b0);
        chk1("rst_no_we", s_i_fill_we, 1'b0);
        tick();
        chk1("rst_stray_no_we", s_i_fill_we, 1'b0);
        for (int j = 0; j < 6; j++) tick();

        // Wrap-around at the top of the address space
        d_miss = 1; d_miss_addr = 16'hFFFA;
        tick();
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (j == 1) chk16("wrap_first_addr", s_mem_addr, 16'hFFF0);
            if (j == 8) chk16("wrap_last_addr", s_mem_addr, 16'hFFFE);
            if (j == 12) chk1("wrap_done", s_d_done, 1'b1);
        end
        d_miss = 0;
        tick();

        // Random requesters
        stray_en = 1'b1;
        quiet = 0;
        for (int c = 0; c < 2500; c++) begin
            if (quiet > 0) begin
                quiet--;
                i_miss = 0; d_miss = 0; d_wr_req = 0;
            end else begin
                if (drop_i) i_miss = 0;
                else if (!i_miss && $urandom_range(0, 5) == 0) begin
                    i_miss = 1; i_miss_addr = rand_addr();
                end
                if (drop_d) d_miss = 0;
                else if (!d_miss && $urandom_range(0, 7) == 0) begin
                    d_miss = 1; d_miss_addr = rand_addr();
                end
                if (drop_w) d_wr_req = 0;
                else if (!d_wr_req && $urandom_range(0, 5) == 0) begin
                    d_wr_req = 1; d_wr_addr = rand_addr(); d_wr_data = 16'($urandom);
                end
            end
            rst = (quiet == 0) && ($urandom_range(0, 399) == 0);
            if (rst) quiet = 12;
            tick();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
